// File: rtl/seg7_mod_counter_if.sv
// seg7_mod_counter_if: control and display signals of seg7_mod_counter
interface seg7_mod_counter_if #(
  parameter int DIGITS = 2
);
  logic en;
  logic up;
  logic load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] count;
  logic carry;
  logic [6:0] seg;
  logic [DIGITS-1:0] dig_sel;
  modport master (output en, up, load, load_val, input count, carry, seg, dig_sel);
  modport slave (input en, up, load, load_val, output count, carry, seg, dig_sel);
endinterface

// File: rtl/seg7_mod_counter.sv
// seg7_mod_counter: multi-digit modulo counter with muxed 7-seg driver; SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
module seg7_mod_counter #(
  parameter int DIGITS = 2,
  parameter int MODULUS = 10,
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 8
) (
  input logic clk,
  input logic rst_n,
  seg7_mod_counter_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [3:0] MAX = 4'(MODULUS - 1);
  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [PW-1:0] pre;
  logic [SW-1:0] scan;
  logic [IW-1:0] idx, idx_nxt;
  logic [4*DIGITS-1:0] cnt, cnt_step, cnt_load, cnt_nxt;
  logic [DIGITS:0] chain;
  logic tick, step, carry_q, blank;
  logic [6:0] seg_q;
  logic [DIGITS-1:0] sel_q;
  assign tick = pre == PW'(PRESCALE - 1);
  assign step = tick & bus.en;
  assign chain[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [3:0] cur, ld;
    assign cur = cnt[4*d +: 4];
    assign ld = bus.load_val[4*d +: 4];
    assign chain[d+1] = chain[d] & (bus.up ? cur == MAX : cur == 4'd0);
    assign cnt_step[4*d +: 4] = !chain[d] ? cur :
                                bus.up ? (cur == MAX ? 4'd0 : cur + 4'd1) :
                                (cur == 4'd0 ? MAX : cur - 4'd1);
    assign cnt_load[4*d +: 4] = ld > MAX ? MAX : ld;
  end
  assign cnt_nxt = bus.load ? cnt_load : step ? cnt_step : cnt;
  assign idx_nxt = scan != SW'(SCAN_DIV - 1) ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = idx_nxt != '0;
    for (int i = 0; i < DIGITS; i++)
      if (i >= int'(idx_nxt) && cnt_nxt[4*i +: 4] != 4'd0) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif
  // seg/dig_sel load from next-state values so they always match the registered count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      scan <= '0;
      idx <= '0;
      cnt <= '0;
      carry_q <= 1'b0;
      sel_q <= DIGITS'(1);
      seg_q <= 7'h3F;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      scan <= scan == SW'(SCAN_DIV - 1) ? '0 : scan + 1'b1;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      carry_q <= !bus.load & step & chain[DIGITS];
      sel_q <= DIGITS'(1) << idx_nxt;
      seg_q <= blank ? 7'h00 : LUT[cnt_nxt[4*idx_nxt +: 4]];
    end
  end
  assign bus.count = cnt;
  assign bus.carry = carry_q;
  assign bus.seg = seg_q;
  assign bus.dig_sel = sel_q;
endmodule

// File: tb/tb_seg7_mod_counter.sv
// tb_seg7_mod_counter: randomized scoreboard bench against an arithmetic model of the counter
module tb_seg7_mod_counter;
  localparam int D = 2;
  localparam int M = 10;
  localparam int P = 4;
  localparam int S = 8;
  localparam int TOT = M ** D;
  typedef struct packed {
    logic [4*D-1:0] count;
    logic carry;
    logic [6:0] seg;
    logic [D-1:0] sel;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int v = 0;
  int k = 0;
  int checks = 0;
  int fails = 0;
  seg7_mod_counter_if #(.DIGITS(D)) bus ();
  seg7_mod_counter #(.DIGITS(D), .MODULUS(M), .PRESCALE(P), .SCAN_DIV(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] font(int n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction
  function automatic int pw(int e);
    int p = 1;
    for (int i = 0; i < e; i++) p *= M;
    return p;
  endfunction
  function automatic logic [4*D-1:0] to_nib(int x);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((x / pw(i)) % M);
    return r;
  endfunction
  function automatic int clamp(logic [4*D-1:0] lv);
    int s = 0;
    for (int i = 0; i < D; i++) s += (int'(lv[4*i +: 4]) > M - 1 ? M - 1 : int'(lv[4*i +: 4])) * pw(i);
    return s;
  endfunction
  function automatic logic [6:0] disp(int x, int idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (idx > 0 && x / pw(idx) == 0) return 7'h00;
`endif
    return font((x / pw(idx)) % M);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic reset_cycle();
    exp_t x;
    @(negedge clk);
    #2 rst_n = 1'b0;
    v = 0;
    k = 0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_carry", 32'(bus.carry), 0);
    chk("rst_seg", 32'(bus.seg), 32'h3F);
    chk("rst_dig_sel", 32'(bus.dig_sel), 1);
    x.count = '0;
    x.carry = 1'b0;
    x.seg = 7'h3F;
    x.sel = D'(1);
    q.push_back(x);
  endtask
  task automatic cycle(input logic l, input logic [4*D-1:0] lv, input logic e, input logic u);
    exp_t x;
    int idx;
    logic c;
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = l;
    bus.load_val = lv;
    bus.en = e;
    bus.up = u;
    k++;
    c = 1'b0;
    if (l) v = clamp(lv);
    else if (e && (k - 1) % P == P - 1) begin
      c = u ? v == TOT - 1 : v == 0;
      v = u ? (v + 1) % TOT : (v + TOT - 1) % TOT;
    end
    idx = (k / S) % D;
    x.count = to_nib(v);
    x.carry = c;
    x.seg = disp(v, idx);
    x.sel = D'(1) << idx;
    q.push_back(x);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count", 32'(bus.count), 32'(x.count));
        chk("carry", 32'(bus.carry), 32'(x.carry));
        chk("seg", 32'(bus.seg), 32'(x.seg));
        chk("dig_sel", 32'(bus.dig_sel), 32'(x.sel));
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.en = 1'b0;
    bus.up = 1'b1;
    bus.load = 1'b0;
    bus.load_val = '0;
    repeat (2) reset_cycle();
    for (int i = 0; i < TOT * P + 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < P; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < P; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    while (k % P != P - 1) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'hCB, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h47, 1'b0, 1'b1);
    for (int i = 0; i < 4 * S; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 8'h05, 1'b0, 1'b1);
    for (int i = 0; i < 2 * S; i++) cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(15) == 0, 8'($urandom), $urandom_range(3) != 0, 1'($urandom));
    cycle(1'b1, 8'h37, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b1);
    reset_cycle();
    for (int i = 0; i < 3 * P; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
